countdown_timer: RTL

//  Loadable down-counter/interval timer with start/pause control and a terminal-count pulse.

---
 rtl/countdown_timer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Loadable down-counter / interval timer. The counter counts down from the
//   loaded value to zero and pulses tc at the terminal count. In one-shot mode
//   it stops in DONE. In auto-reload mode it reloads and keeps running, which
//   makes it a periodic tick generator.
//
// Ports
//   clk          system clock; all activity on the rising edge
//   rst_n        synchronous active-low reset
//   load         capture load_val into q and the reload register; aborts a count
//   load_val     value captured on load (W bits)
//   start        begin counting from IDLE, or re-arm from DONE
//   pause        hold q while RUN; has no effect in other states
//   auto_reload  1 = reload at terminal count and keep running
//   q            current count (W bits)
//   busy         1 while the timer is running
//   done         1 while a one-shot count has expired
//   tc           one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    input  logic         auto_reload,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         tc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    state_t       state_r;
    state_t       state_nxt_s;
    logic [W-1:0] q_r;
    logic [W-1:0] q_nxt_s;
    logic [W-1:0] reload_r;
    logic [W-1:0] reload_nxt_s;
    logic         tc_r;
    logic         tc_nxt_s;
    logic         busy_r;
    logic         busy_nxt_s;
    logic         done_r;
    logic         done_nxt_s;

    // State, count and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            q_r      <= CNT_ZERO;
            reload_r <= CNT_ZERO;
            tc_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            q_r      <= q_nxt_s;
            reload_r <= reload_nxt_s;
            tc_r     <= tc_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    // Next-state and next-count logic; load overrides start/pause.
    always_comb begin
        state_nxt_s  = state_r;
        q_nxt_s      = q_r;
        reload_nxt_s = reload_r;
        tc_nxt_s     = 1'b0;
        if (load) begin
            q_nxt_s      = load_val;
            reload_nxt_s = load_val;
            state_nxt_s  = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (q_r != CNT_ZERO) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            // Nothing to count: expire immediately.
                            state_nxt_s = ST_DONE;
                            tc_nxt_s    = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_nxt_s = ST_RUN;
                    end else if (q_r > CNT_ONE) begin
                        q_nxt_s = q_r - CNT_ONE;
                    end else if (q_r == CNT_ONE) begin
                        tc_nxt_s = 1'b1;
                        if (auto_reload && (reload_r != CNT_ZERO)) begin
                            // Reload instead of showing zero keeps the period at N.
                            q_nxt_s = reload_r;
                        end else begin
                            q_nxt_s     = CNT_ZERO;
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        // q==0 cannot be reached while running; park safely.
                        q_nxt_s     = CNT_ZERO;
                        state_nxt_s = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start && (reload_r != CNT_ZERO)) begin
                        q_nxt_s     = reload_r;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    q_nxt_s     = CNT_ZERO;
                end
            endcase
        end
    end

    // Status decode from the next state so busy/done register alongside it.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_RUN:  busy_nxt_s = 1'b1;
            ST_DONE: done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    assign q    = q_r;
    assign busy = busy_r;
    assign done = done_r;
    assign tc   = tc_r;

endmodule
